md_seq_unit: RTL and testbench



---
 rtl/md_seq_unit_pkg.sv | 35 +++
 rtl/md_seq_unit_dp.sv | 59 +++++
 rtl/md_seq_unit.sv | 166 ++++++++++++++++
 tb/tb_md_seq_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/md_seq_unit_pkg.sv
// md_seq_unit shared definitions: RV32M funct3 codes, sequencer states
// and operand signedness helpers.
package md_seq_unit_pkg;

    localparam logic [2:0] MD_OP_MUL    = 3'd0;
    localparam logic [2:0] MD_OP_MULH   = 3'd1;
    localparam logic [2:0] MD_OP_MULHSU = 3'd2;
    localparam logic [2:0] MD_OP_MULHU  = 3'd3;
    localparam logic [2:0] MD_OP_DIV    = 3'd4;
    localparam logic [2:0] MD_OP_DIVU   = 3'd5;
    localparam logic [2:0] MD_OP_REM    = 3'd6;
    localparam logic [2:0] MD_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_ITER = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic md_rs1_signed(input logic [2:0] op);
        return !(op == MD_OP_MULHU || op == MD_OP_DIVU ||
                 op == MD_OP_REMU);
    endfunction

    function automatic logic md_rs2_signed(input logic [2:0] op);
        return op == MD_OP_MUL || op == MD_OP_MULH ||
               op == MD_OP_DIV || op == MD_OP_REM;
    endfunction

endpackage

// File: rtl/md_seq_unit_dp.sv
// md_iter_dp: 64-bit {hi,lo} accumulator for shift-add multiply and
// restoring divide, one step per enabled cycle.
import md_seq_unit_pkg::*;

module md_iter_dp #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic [2*DATA_WIDTH-1:0]   acc_init_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    input  logic                      en_i,
    input  logic                      is_div_i,
    output logic [2*DATA_WIDTH-1:0]   acc_o
);

    localparam int W = DATA_WIDTH;

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   b_q, b_d;
    logic [W:0]     sum, top, diff;
    logic [2*W:0]   sh;

    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q};
        sh    = {acc_q, 1'b0};
        top   = sh[2*W:W];
        diff  = top - {1'b0, b_q};
        if (load_i) begin
            acc_d = acc_init_i;
            b_d   = b_i;
        end else if (en_i) begin
            if (is_div_i) begin
                // trial subtract on the 33-bit shifted remainder
                if (!diff[W]) acc_d = {diff[W-1:0], sh[W-1:1], 1'b1};
                else          acc_d = sh[2*W-1:0];
            end else begin
                if (acc_q[0]) acc_d = {sum, acc_q[W-1:1]};
                else          acc_d = {1'b0, acc_q[2*W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/md_seq_unit.sv
// md_seq_unit: RV32M multiply/divide sequencer beside the execute ALU.
// Define MD_FAST_MUL_EN for a single-cycle multiply product at accept.
import md_seq_unit_pkg::*;

module md_seq_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic                  kill_i,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  result_valid_o
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]   INT_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);

    md_state_e state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]   op_q, op_d;
    logic         neg_q, neg_d;
    logic         negr_q, negr_d;
    logic [W-1:0] result_q, result_d;

    logic           s1, s2, div0, ovf, load;
    logic [W-1:0]   mag1, mag2, dp_b, quo, rem, fix_res;
    logic [2*W-1:0] acc_init, acc, prod;

`ifdef MD_FAST_MUL_EN
    logic signed [W:0]     fa, fb;
    logic signed [2*W+1:0] fp;
    assign fa = {s1 & rs1_i[W-1], rs1_i};
    assign fb = {s2 & rs2_i[W-1], rs2_i};
    assign fp = fa * fb;
`endif

    always_comb begin
        s1   = md_rs1_signed(op_i) & rs1_i[W-1];
        s2   = md_rs2_signed(op_i) & rs2_i[W-1];
        mag1 = s1 ? (~rs1_i + ONE_W) : rs1_i;
        mag2 = s2 ? (~rs2_i + ONE_W) : rs2_i;
        div0 = md_is_div(op_i) && (rs2_i == '0);
        ovf  = (op_i == MD_OP_DIV || op_i == MD_OP_REM) &&
               (rs1_i == INT_MIN) && (rs2_i == '1);
        if (md_is_div(op_i)) begin
            acc_init = {{W{1'b0}}, mag1};
            dp_b     = mag2;
        end else begin
            acc_init = {{W{1'b0}}, mag2};
            dp_b     = mag1;
        end
        // special cases preload final {rem, quo}; sign fix is bypassed
        if (div0)     acc_init = {rs1_i, {W{1'b1}}};
        else if (ovf) acc_init = {{W{1'b0}}, INT_MIN};
`ifdef MD_FAST_MUL_EN
        if (!md_is_div(op_i)) acc_init = fp[2*W-1:0];
`endif
    end

    md_iter_dp #(
        .DATA_WIDTH(W)
    ) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .acc_init_i(acc_init),
        .b_i       (dp_b),
        .en_i      (state_q == MD_ITER),
        .is_div_i  (md_is_div(op_q)),
        .acc_o     (acc)
    );

    always_comb begin
        prod = neg_q ? (~acc + ONE_2W) : acc;
        quo  = neg_q ? (~acc[W-1:0] + ONE_W) : acc[W-1:0];
        rem  = negr_q ? (~acc[2*W-1:W] + ONE_W) : acc[2*W-1:W];
        unique case (op_q)
            MD_OP_MUL:              fix_res = prod[W-1:0];
            MD_OP_DIV, MD_OP_DIVU:  fix_res = quo;
            MD_OP_REM, MD_OP_REMU:  fix_res = rem;
            default:                fix_res = prod[2*W-1:W];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        result_d = result_q;
        load     = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (!kill_i && op_valid_i) begin
                    load   = 1'b1;
                    op_d   = op_i;
                    cnt_d  = '0;
                    neg_d  = s1 ^ s2;
                    negr_d = s1;
                    state_d = MD_ITER;
                    if (div0 || ovf) begin
                        neg_d   = 1'b0;
                        negr_d  = 1'b0;
                        state_d = MD_FIX;
                    end
`ifdef MD_FAST_MUL_EN
                    if (!md_is_div(op_i)) begin
                        neg_d   = 1'b0;
                        state_d = MD_FIX;
                    end
`endif
                end
            end
            MD_ITER: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (kill_i) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (!kill_i) begin
                    result_d = fix_res;
                    state_d  = MD_DONE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign busy_o         = (state_q == MD_ITER) | (state_q == MD_FIX);
    assign result_valid_o = (state_q == MD_DONE);
    assign result_o       = result_q;

endmodule

// File: tb/tb_md_seq_unit.sv
// Directed bench for md_seq_unit: RV32M results, latency, special
// divides, kill, back-to-back accept and asynchronous reset.
module tb_md_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        kill;
    logic        busy;
    logic [31:0] result;
    logic        valid;

    int n_run  = 0;
    int n_fail = 0;

`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    always #5 clk = ~clk;

    md_seq_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid_i    (op_valid),
        .op_i          (op),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .kill_i        (kill),
        .busy_o        (busy),
        .result_o      (result),
        .result_valid_o(valid)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // call at posedge+1 with the unit idle; returns one cycle after valid
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat = 0;
        int nbusy = 0;
        op = o; rs1 = a; rs2 = b; op_valid = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) op_valid = 1'b0;
            if (busy) nbusy++;
        end while (!valid && lat < 100);
        check({tag, " result"}, result, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(nbusy), 32'(exp_lat - 1));
        @(posedge clk); #1;
        check({tag, " pulse"}, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; op_valid = 1'b0; op = '0;
        rs1 = '0; rs2 = '0; kill = 1'b0;
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, MUL_LAT);
        run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, MUL_LAT);
        run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, MUL_LAT);
        run_op("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        run_op("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 34);
        run_op("DIV0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("REM0", 3'd6, 32'd5, 32'd0, 32'd5, 2);
        run_op("DIVOVF", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 2);
        run_op("REMOVF", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
        run_op("REMU2", 3'd7, 32'd100, 32'd7, 32'd2, 34);

        // kill in the tenth ITER cycle
        op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("kill busy before", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill busy", {31'd0, busy}, 32'd0);
        lat = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) lat++;
        end
        check("kill no pulse", 32'(lat), 32'd0);
        check("kill result kept", result, 32'd2);
        run_op("DIVU after kill", 3'd5, 32'd9, 32'd3, 32'd3, 34);

        // back-to-back: request held high across DONE
        op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; op_valid = 1'b1;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end
        while (!valid && lat < 100);
        check("b2b first latency", 32'(lat), 32'd34);
        check("b2b first result", result, 32'd14);
        op = 3'd7;
        @(posedge clk); #1;
        check("b2b idle busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("b2b reaccept busy", {31'd0, busy}, 32'd1);
        op_valid = 1'b0;
        lat = 1;
        do begin @(posedge clk); #1; lat++; end
        while (!valid && lat < 100);
        check("b2b second latency", 32'(lat), 32'd34);
        check("b2b second result", result, 32'd2);
        @(posedge clk); #1;

        // asynchronous reset mid-ITER
        op = 3'd3; rs1 = 32'd12345; rs2 = 32'd678; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", {31'd0, busy}, 32'd0);
        check("arst result", result, 32'd0);
        check("arst valid", {31'd0, valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("MUL after reset", 3'd0, 32'd6, 32'd7, 32'd42, MUL_LAT);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
